keypad_add_ctrl: RTL and testbench

KEYPAD_ADD_CTRL -- requirements
Module: keypad_add_ctrl

---
 rtl/keypad_add_ctrl_if.sv | 25 ++
 rtl/keypad_add_ctrl.sv | 170 +++++++++++++++++
 tb/tb_keypad_add_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_add_ctrl_if.sv
// Connection bundle between the keypad/adder controller and its neighbours:
// matrix scanner inputs, serial adder handshake and the display-facing status.
interface keypad_add_ctrl_if;
  logic       key_flag;
  logic [4:0] key_code;
  logic       add_start;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_done;
  logic [8:0] add_sum;
  logic [8:0] result;
  logic       result_valid;
  logic [2:0] state_code;
  logic       err;

  modport master (
    input  key_flag, key_code, add_done, add_sum,
    output add_start, add_a, add_b, result, result_valid, state_code, err
  );

  modport slave (
    output key_flag, key_code, add_done, add_sum,
    input  add_start, add_a, add_b, result, result_valid, state_code, err
  );
endinterface

// File: rtl/keypad_add_ctrl.sv
// Keypad-driven two-operand adder controller: debounces key presses, collects
// operands A and B, launches the serial adder and captures its sum.
module keypad_add_ctrl #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk_in,
  input  logic              rst,
  keypad_add_ctrl_if.master bus
);
  localparam int unsigned DW = 4;
  localparam int unsigned TW = 16;
  localparam logic [DW-1:0] DEB_N   = DW'(DEB_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4,
    ERROR   = 3'd5
  } state_e;

  logic          key_ok;
  logic [DW-1:0] press_cnt_q, press_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic [DW-1:0] press_next;
  logic [3:0]    code_q, code_d;
  logic          lock_q, lock_d;
  logic          acc_q, acc_d;
  logic [3:0]    acc_code_q, acc_code_d;

  state_e        state_q;
  logic [7:0]    a_q, b_q;
  logic [8:0]    result_q;
  logic          rv_q, err_q, start_q;
  logic [TW-1:0] to_cnt_q;

  logic key_digit, key_enter, key_clear, do_clear;

  // Codes 12..31 behave exactly like an idle keypad.
  assign key_ok = bus.key_flag && (bus.key_code <= 5'd11);

  // Press/release debounce; lock_q holds off further presses until a clean release.
  always_comb begin
    press_cnt_d = '0;
    rel_cnt_d   = '0;
    code_d      = code_q;
    lock_d      = lock_q;
    acc_d       = 1'b0;
    acc_code_d  = acc_code_q;
    press_next  = ((press_cnt_q != '0) && (bus.key_code[3:0] == code_q)) ?
                  press_cnt_q + DW'(1) : DW'(1);
    if (lock_q) begin
      if (!key_ok) begin
        rel_cnt_d = rel_cnt_q + DW'(1);
        if (rel_cnt_d == DEB_N) begin
          lock_d    = 1'b0;
          rel_cnt_d = '0;
        end
      end
    end else if (key_ok) begin
      code_d = bus.key_code[3:0];
      if (press_next == DEB_N) begin
        acc_d      = 1'b1;
        acc_code_d = bus.key_code[3:0];
        lock_d     = 1'b1;
      end else begin
        press_cnt_d = press_next;
      end
    end
  end

  assign key_digit = acc_q && (acc_code_q <= 4'd9);
  assign key_enter = acc_q && (acc_code_q == 4'd10);
  assign key_clear = acc_q && (acc_code_q == 4'd11);
  assign do_clear  = key_clear && ((state_q == ENTER_A) || (state_q == ENTER_B) ||
                                   (state_q == SHOW)    || (state_q == ERROR));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      press_cnt_q <= '0;
      rel_cnt_q   <= '0;
      code_q      <= '0;
      lock_q      <= 1'b0;
      acc_q       <= 1'b0;
      acc_code_q  <= '0;
      state_q     <= ENTER_A;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      press_cnt_q <= press_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      code_q      <= code_d;
      lock_q      <= lock_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      start_q     <= 1'b0;
      if (do_clear) begin
        state_q  <= ENTER_A;
        a_q      <= '0;
        b_q      <= '0;
        result_q <= '0;
        rv_q     <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (key_digit)      a_q     <= {a_q[3:0], acc_code_q};
            else if (key_enter) state_q <= ENTER_B;
          end
          ENTER_B: begin
            if (key_digit) begin
              b_q <= {b_q[3:0], acc_code_q};
            end else if (key_enter) begin
              state_q <= START;
              start_q <= 1'b1;
            end
          end
          START: begin
            to_cnt_q <= '0;
            state_q  <= WAIT;
          end
          // A done pulse on the final timeout cycle still counts as success.
          WAIT: begin
            if (bus.add_done) begin
              result_q <= bus.add_sum;
              rv_q     <= 1'b1;
              state_q  <= SHOW;
            end else if (to_cnt_q == TO_LAST) begin
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
            end
          end
          SHOW: begin
            if (key_digit) begin
              a_q     <= {4'h0, acc_code_q};
              b_q     <= '0;
              rv_q    <= 1'b0;
              state_q <= ENTER_A;
            end else if (key_enter) begin
              rv_q    <= 1'b0;
              start_q <= 1'b1;
              state_q <= START;
            end
          end
          ERROR: state_q <= ERROR;
          default: state_q <= ENTER_A;
        endcase
      end
    end
  end

  assign bus.add_start    = start_q;
  assign bus.add_a        = a_q;
  assign bus.add_b        = b_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.state_code   = state_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_keypad_add_ctrl.sv
// Randomized scoreboard bench for keypad_add_ctrl: a key-level model predicts every
// visible output change and the edge it lands on; a monitor checks them in order.
module tb_keypad_add_ctrl;
  localparam int DEB = 4;
  localparam int TO  = 16;
  localparam logic [2:0] SC_A = 3'd0, SC_B = 3'd1, SC_START = 3'd2,
                         SC_WAIT = 3'd3, SC_SHOW = 3'd4, SC_ERR = 3'd5;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [8:0]  res;
    logic        rv;
    logic        err;
    logic        start;
    int unsigned e;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic       rst_main, rst_add, rst;
  logic       kf_main, kf_wait;
  logic [4:0] kc_main, kc_wait;

  keypad_add_ctrl_if bus();
  assign rst          = rst_main | rst_add;
  assign bus.key_flag = kf_main | kf_wait;
  assign bus.key_code = kf_wait ? kc_wait : kc_main;

  keypad_add_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  snap_t       exp_q[$];
  snap_t       m, last_s, cur_s, prev_s, exp_s;
  int unsigned busy_until = 0;
  int          force_kd = 0, force_rst = 0;
  bit          force_sum_en = 1'b0;
  logic [8:0]  force_sum = '0;
  int unsigned plan_s = 0;
  int          plan_kd = 0, plan_r = 0, plan_seq = 0, adder_seen = 0;
  bit          plan_key = 1'b0;
  logic [8:0]  plan_sum = '0;
  bit          mon_en = 1'b0, mon_first = 1'b1, stim_done = 1'b0;
  int          checks = 0, errors = 0;

  function automatic snap_t zero_snap();
    snap_t s;
    s.st = SC_A; s.a = '0; s.b = '0; s.res = '0;
    s.rv = 1'b0; s.err = 1'b0; s.start = 1'b0; s.e = 0;
    return s;
  endfunction

  function automatic bit differs(snap_t x, snap_t y);
    return (x.st !== y.st) || (x.a !== y.a) || (x.b !== y.b) || (x.res !== y.res) ||
           (x.rv !== y.rv) || (x.err !== y.err) || (x.start !== y.start);
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d a=%h b=%h res=%h rv=%b err=%b start=%b at_edge=%0d",
                     s.st, s.a, s.b, s.res, s.rv, s.err, s.start, s.e);
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.st = bus.state_code; s.a = bus.add_a; s.b = bus.add_b; s.res = bus.result;
    s.rv = bus.result_valid; s.err = bus.err; s.start = bus.add_start; s.e = edge_n;
    return s;
  endfunction

  // Queue the model's new visible state if it differs from the last one queued.
  function automatic void commit(int unsigned e);
    if (differs(m, last_s)) begin
      m.e = e;
      exp_q.push_back(m);
      last_s = m;
    end
  endfunction

  task automatic go_start(input int unsigned e);
    int kd, rr;
    logic [8:0] sum;
    bit wk;
    m.st = SC_START; m.start = 1'b1; commit(e);
    m.st = SC_WAIT;  m.start = 1'b0; commit(e + 1);
    kd = 0; rr = 0;
    if (force_rst > 0) rr = force_rst;
    else if (force_kd > 0) kd = force_kd;
    else if ($urandom_range(0, 9) == 0) rr = $urandom_range(1, TO);
    else begin
      case ($urandom_range(0, 5))
        0, 1:    kd = $urandom_range(TO + 1, TO + 4);
        2:       kd = TO;
        default: kd = $urandom_range(1, TO - 1);
      endcase
    end
    sum = force_sum_en ? force_sum : 9'($urandom);
    force_rst = 0; force_kd = 0; force_sum_en = 1'b0;
    wk = (rr == 0) && (((kd < TO) ? kd : TO) >= 2 * DEB + 4) && ($urandom_range(0, 1) == 1);
    if (rr > 0) begin
      m = zero_snap();
      commit(e + 1 + rr);
      busy_until = e + 1 + rr;
    end else if (kd <= TO) begin
      m.st = SC_SHOW; m.res = sum; m.rv = 1'b1;
      commit(e + 1 + kd);
      busy_until = e + 1 + kd;
    end else begin
      m.st = SC_ERR; m.err = 1'b1;
      commit(e + 1 + TO);
      busy_until = e + 1 + TO;
    end
    plan_s = e; plan_kd = kd; plan_r = rr; plan_key = wk; plan_sum = sum;
    plan_seq++;
  endtask

  // Key-level behaviour: what an accepted key does to the calculator.
  task automatic model_key(input int code, input int unsigned e);
    bit started;
    started = 1'b0;
    if (code == 11 && (m.st == SC_A || m.st == SC_B || m.st == SC_SHOW || m.st == SC_ERR)) begin
      m = zero_snap();
    end else begin
      case (m.st)
        SC_A: if (code <= 9) m.a = {m.a[3:0], 4'(code)};
              else if (code == 10) m.st = SC_B;
        SC_B: if (code <= 9) m.b = {m.b[3:0], 4'(code)};
              else if (code == 10) begin go_start(e); started = 1'b1; end
        SC_SHOW: if (code <= 9) begin
                   m.a = {4'h0, 4'(code)}; m.b = '0; m.rv = 1'b0; m.st = SC_A;
                 end else if (code == 10) begin
                   m.rv = 1'b0; go_start(e); started = 1'b1;
                 end
        default: ;
      endcase
    end
    if (!started) commit(e);
  endtask

  // Hold pre_code for n1 edges, then code for n2 edges, then release for rel edges.
  task automatic press(input int pre_code, input int n1, input int code, input int n2, input int rel);
    int unsigned e0;
    e0 = edge_n;
    if (code <= 11 && n2 >= DEB) model_key(code, e0 + n1 + DEB + 1);
    for (int i = 0; i < n1; i++) begin
      kf_main = 1'b1; kc_main = 5'(pre_code); @(posedge clk); #1;
    end
    for (int i = 0; i < n2; i++) begin
      kf_main = 1'b1; kc_main = 5'(code); @(posedge clk); #1;
    end
    kf_main = 1'b0; kc_main = 5'($urandom);
    repeat (rel) begin @(posedge clk); #1; end
    while (edge_n < busy_until + DEB + 2) begin @(posedge clk); #1; end
  endtask

  task automatic key(input int code);
    press(0, 0, code, DEB, DEB);
  endtask

  // Adder side: answers each launch as planned, may press a key mid-WAIT, then
  // sends one stray done pulse once the controller has left WAIT.
  initial begin : adder
    logic [4:0] wcode;
    int last;
    bus.add_done = 1'b0; bus.add_sum = '0; rst_add = 1'b0; kf_wait = 1'b0; kc_wait = '0;
    forever begin
      wait (plan_seq != adder_seen);
      adder_seen = plan_seq;
      wcode = 5'($urandom_range(0, 9));
      while (edge_n < plan_s + 1) begin @(posedge clk); #1; end
      last = (plan_r > 0) ? plan_r : ((plan_kd <= TO) ? plan_kd : TO);
      for (int k = 1; k <= last; k++) begin
        bus.add_done = (plan_r == 0) && (k == plan_kd);
        bus.add_sum  = (k == plan_kd) ? plan_sum : 9'($urandom);
        rst_add      = (k == plan_r);
        kf_wait      = plan_key && (k >= DEB + 2) && (k <= 2 * DEB + 2);
        kc_wait      = wcode;
        @(posedge clk); #1;
      end
      bus.add_done = 1'b0; rst_add = 1'b0; kf_wait = 1'b0;
      @(posedge clk); #1;
      bus.add_done = 1'b1; bus.add_sum = 9'($urandom);
      @(posedge clk); #1;
      bus.add_done = 1'b0;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_s = observe();
        if (mon_first) begin
          mon_first = 1'b0;
          checks++;
          if (differs(cur_s, zero_snap())) begin
            errors++;
            $display("FAIL reset_state got %s required %s", fmt(cur_s), fmt(zero_snap()));
          end
          prev_s = cur_s;
        end else if (differs(cur_s, prev_s)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got %s required no change", fmt(cur_s));
          end else begin
            exp_s = exp_q.pop_front();
            if (differs(cur_s, exp_s) || cur_s.e != exp_s.e) begin
              errors++;
              $display("FAIL transition got %s required %s", fmt(cur_s), fmt(exp_s));
            end
          end
          prev_s = cur_s;
        end
        if (stim_done) begin
          checks++;
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_changes got %0d required 0 (next %s)", exp_q.size(), fmt(exp_q[0]));
          end
          checks++;
          if (differs(cur_s, m)) begin
            errors++;
            $display("FAIL final_state got %s required %s", fmt(cur_s), fmt(m));
          end
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
      if (edge_n > 60000) begin
        errors++;
        $display("FAIL timeout got edge %0d required stimulus to finish", edge_n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : stimulus
    int kind, code, c1;
    rst_main = 1'b1; kf_main = 1'b0; kc_main = '0;
    m = zero_snap(); last_s = zero_snap();
    repeat (3) @(posedge clk);
    #1;
    rst_main = 1'b0;
    mon_en   = 1'b1;

    key(3); key(7); key(10);
    key(11);
    press(2, 3, 5, 40, DEB);
    key(11);
    key(1); key(2); key(10); key(3); key(4);
    force_kd = 3; force_sum = 9'h046; force_sum_en = 1'b1; key(10);
    force_kd = TO + 4; key(10);
    for (int c = 0; c <= 10; c++) key(c);
    key(11);
    key(5); key(10); key(6);
    force_kd = TO; key(10);
    force_rst = 5; key(10);
    key(1); key(2); key(3); key(10); key(8);
    force_kd = 2; key(10);
    key(9);

    for (int it = 0; it < 90; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: code = $urandom_range(0, 9);
          6, 7:             code = 10;
          default:          code = 11;
        endcase
        press(0, 0, code, $urandom_range(DEB, DEB + 2), $urandom_range(DEB, DEB + 2));
      end else if (kind == 6) begin
        press(0, 0, $urandom_range(0, 11), $urandom_range(1, DEB - 1), DEB);
      end else if (kind == 7) begin
        press(0, 0, $urandom_range(12, 31), $urandom_range(1, 12), DEB);
      end else begin
        c1   = $urandom_range(0, 11);
        code = (c1 + $urandom_range(1, 11)) % 12;
        press(c1, $urandom_range(1, DEB - 1), code, $urandom_range(DEB, DEB + 2), DEB);
      end
    end

    repeat (DEB + 10) @(posedge clk);
    #1;
    stim_done = 1'b1;
  end

endmodule
